// File: rtl/rv32_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, responder FSM states and
// the sizing/extension helpers used by the data-memory responder.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  // Select the addressed byte/half from a stored word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'h0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'h0, h};
      F3_W:    load_extend = word;
      default: load_extend = 32'h0;
    endcase
  endfunction

  // Byte-lane write enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    store_be = 4'b0001 << addr_lo;
      F3_H:    store_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Legal funct3 for the direction and naturally aligned for its size.
  function automatic logic access_ok(input logic [2:0] funct3,
                                     input logic       write,
                                     input logic [1:0] addr_lo);
    access_ok = 1'b0;
    if (write) begin
      case (funct3)
        F3_B:    access_ok = 1'b1;
        F3_H:    access_ok = ~addr_lo[0];
        F3_W:    access_ok = (addr_lo == 2'b00);
        default: access_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: access_ok = 1'b1;
        F3_H, F3_HU: access_ok = ~addr_lo[0];
        F3_W:        access_ok = (addr_lo == 2'b00);
        default:     access_ok = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word array with per-byte write enables and a registered read.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and read-first capture, both only when enabled.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per handshake, checks it,
// commits it to the array on the edge entering RESP and pulses a response.
module dmem_responder
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept, enter_resp;

  // Hold register: the accepted request, already checked.
  logic          hold_write_q;
  logic [1:0]    hold_lo_q;
  logic [31:0]   hold_wdata_q;
  logic [2:0]    hold_f3_q;
  logic          hold_ok_q;
  logic [AW-1:0] hold_idx_q;

  logic [31:0]   req_idx;
  logic          req_ok;

  // Fields of the access being committed this edge.
  logic          acc_write, acc_ok;
  logic [1:0]    acc_lo;
  logic [31:0]   acc_wdata, acc_wrep;
  logic [2:0]    acc_f3;
  logic [AW-1:0] acc_idx;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;

  logic [31:0]   live_rdata, rsp_rdata_q;
  logic          rsp_err_q;

  // Unsigned subtract wraps addresses below the base to huge indices, which
  // the range compare then rejects.
  assign req_idx = (bus.req_addr - ADDR_BASE) >> 2;
  assign req_ok  = (req_idx < 32'(DEPTH_WORDS)) &&
                   access_ok(bus.req_funct3, bus.req_write, bus.req_addr[1:0]);

  // Next-state logic: accept in IDLE or RESP, count down in WAIT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entering RESP from WAIT commits the held request; from IDLE/RESP (no wait
  // states) it commits the request being accepted on this same edge.
  always_comb begin
    if (state_q == WAIT) begin
      acc_write = hold_write_q;
      acc_ok    = hold_ok_q;
      acc_lo    = hold_lo_q;
      acc_wdata = hold_wdata_q;
      acc_f3    = hold_f3_q;
      acc_idx   = hold_idx_q;
    end else begin
      acc_write = bus.req_write;
      acc_ok    = req_ok;
      acc_lo    = bus.req_addr[1:0];
      acc_wdata = bus.req_wdata;
      acc_f3    = bus.req_funct3;
      acc_idx   = req_idx[AW-1:0];
    end
    case (acc_f3)
      F3_B:    acc_wrep = {4{acc_wdata[7:0]}};
      F3_H:    acc_wrep = {2{acc_wdata[15:0]}};
      default: acc_wrep = acc_wdata;
    endcase
  end

  // Rejected accesses and anything racing a reset never touch the array.
  assign ram_en = enter_resp & acc_ok & ~rst;
  assign ram_we = acc_write ? store_be(acc_f3, acc_lo) : 4'b0000;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (acc_idx),
    .wdata_i(acc_wrep),
    .rdata_o(ram_rdata)
  );

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_write_q <= 1'b0;
      hold_lo_q    <= 2'b00;
      hold_wdata_q <= 32'h0;
      hold_f3_q    <= 3'b000;
      hold_ok_q    <= 1'b0;
      hold_idx_q   <= '0;
    end else if (accept) begin
      hold_write_q <= bus.req_write;
      hold_lo_q    <= bus.req_addr[1:0];
      hold_wdata_q <= bus.req_wdata;
      hold_f3_q    <= bus.req_funct3;
      hold_ok_q    <= req_ok;
      hold_idx_q   <= req_idx[AW-1:0];
    end
  end

  assign live_rdata = (hold_write_q | ~hold_ok_q) ? 32'h0
                    : load_extend(ram_rdata, hold_f3_q, hold_lo_q);

  // Remember the last response so the outputs stay stable between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (state_q == RESP) begin
      rsp_rdata_q <= live_rdata;
      rsp_err_q   <= ~hold_ok_q;
    end
  end

  assign bus.req_ready = (state_q != WAIT);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP) ? live_rdata : rsp_rdata_q;
  assign bus.rsp_err   = (state_q == RESP) ? ~hold_ok_q : rsp_err_q;
endmodule
